// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter and its prescaler.
package counter_pkg;

   // Behaviour when the count runs past either end of its range.
   typedef enum logic {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } cnt_mode_t;

   // Register width for a prescaler that counts 0..value-1; never below one bit.
   function automatic int clog2_min1(input int value);
      int w;
      w = $clog2(value);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and raises tick on the last one.
// With PRESCALE=1 the tick is constantly high and no register is built.
module tick_divider
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   generate
      if (PRESCALE <= 1) begin : g_bypass
         // Inputs are irrelevant when every enabled cycle is a step.
         logic unused_inputs;
         assign unused_inputs = ^{clock, reset_n, clear, enable};
         assign tick = 1'b1;
      end else begin : g_div
         localparam int W = clog2_min1(PRESCALE);
         localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

         logic [W-1:0] pre_q;
         logic [W-1:0] pre_d;

         // Next prescaler value: clear wins, otherwise advance on enable and wrap at LAST.
         always_comb begin
            pre_d = pre_q;
            if (clear) begin
               pre_d = '0;
            end else if (enable) begin
               pre_d = (pre_q == LAST) ? '0 : pre_q + W'(1);
            end
         end

         // Prescaler state register.
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               pre_q <= '0;
            end else begin
               pre_q <= pre_d;
            end
         end

         assign tick = (pre_q == LAST);
      end
   endgenerate

endmodule

// File: rtl/counter_updown_mod.sv
// Up/down counter with runtime modulus, wrap/saturate mode, prescaler and
// cascade carry. Chain stages by feeding carry_out into the next enable.
module counter_updown_mod
   import counter_pkg::*;
#(
   parameter int N        = 4,
   parameter int PRESCALE = 1
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         load,
   input  logic [N-1:0] load_value,
   input  logic         enable,
   input  logic         dec,
   input  cnt_mode_t    mode,
   input  logic [N-1:0] max_value,
   output logic [N-1:0] count,
   output logic         tc,
   output logic         carry_out,
   output logic         boundary_hit
);

   logic         tick;
   logic         step;
   logic         presc_clear;
   logic         tc_raw;
   logic [N-1:0] count_q;
   logic [N-1:0] count_d;
   logic [N-1:0] up_next;
   logic [N-1:0] down_next;
   logic [N-1:0] load_clamped;
   logic         boundary_q;
   logic         boundary_d;

   // Clear and load both restart the prescaler so the first step lands P enabled edges later.
   assign presc_clear = clear | load;

   tick_divider #(
      .PRESCALE(PRESCALE)
   ) u_tick (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (presc_clear),
      .enable  (enable),
      .tick    (tick)
   );

   assign step = enable & tick;

   // Terminal count: at the end of the range in the current direction.
   assign tc_raw = dec ? (count_q == '0) : (count_q >= max_value);

   // Candidate values for a step in each direction, handling wrap/saturate and a lowered modulus.
   always_comb begin
      up_next   = count_q;
      down_next = count_q;
      if (count_q < max_value) begin
         up_next = count_q + N'(1);
      end else if (mode == MODE_SAT) begin
         up_next = max_value;
      end else begin
         up_next = '0;
      end
      if (count_q > max_value) begin
         down_next = max_value;
      end else if (count_q == '0) begin
         down_next = (mode == MODE_WRAP) ? max_value : '0;
      end else begin
         down_next = count_q - N'(1);
      end
   end

   // Loaded values never exceed the current range.
   assign load_clamped = (load_value > max_value) ? max_value : load_value;

   // Next count by priority: clear, load, step, hold.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (load) begin
         count_d = load_clamped;
      end else if (step) begin
         count_d = dec ? down_next : up_next;
      end
   end

   // A step taken at terminal count flags a boundary, unless clear/load overrides the step.
   assign boundary_d = step & tc_raw & ~clear & ~load;

   // Count and boundary event registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q    <= '0;
         boundary_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         boundary_q <= boundary_d;
      end
   end

   // Outputs read zero while reset is held, including the combinational ones.
   assign count        = count_q;
   assign tc           = reset_n & tc_raw;
   assign carry_out    = reset_n & step & tc_raw;
   assign boundary_hit = boundary_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: a P=1 instance, a P=3 instance and a two-stage
// BCD cascade. The driver pushes the expected per-cycle observation into a
// queue; a monitor on the falling edge pops and compares it.
module tb_counter_updown_mod;
   import counter_pkg::*;

   // Queue entry: sel[16:15] mask[14:11] (count,tc,co,bh) count[10:3] tc[2] co[1] bh[0]
   localparam int W = 17;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   // ---------------- instance A: N=4, P=1 ----------------
   logic       a_clr, a_ld, a_en, a_dec;
   logic [3:0] a_ldv, a_max;
   cnt_mode_t  a_mode;
   logic [3:0] a_count;
   logic       a_tc, a_co, a_bh;

   counter_updown_mod #(.N(4), .PRESCALE(1)) dut_a (
      .clock(clock), .reset_n(reset_n), .clear(a_clr), .load(a_ld),
      .load_value(a_ldv), .enable(a_en), .dec(a_dec), .mode(a_mode),
      .max_value(a_max), .count(a_count), .tc(a_tc), .carry_out(a_co),
      .boundary_hit(a_bh)
   );

   // ---------------- instance P: N=4, P=3 ----------------
   logic       p_clr, p_en;
   logic [3:0] p_count;
   logic       p_tc, p_co, p_bh;

   counter_updown_mod #(.N(4), .PRESCALE(3)) dut_p (
      .clock(clock), .reset_n(reset_n), .clear(p_clr), .load(1'b0),
      .load_value(4'd0), .enable(p_en), .dec(1'b0), .mode(MODE_WRAP),
      .max_value(4'd9), .count(p_count), .tc(p_tc), .carry_out(p_co),
      .boundary_hit(p_bh)
   );

   // ---------------- cascade: two BCD digits ----------------
   logic       c_clr, c_en;
   logic [3:0] c0_count, c1_count;
   logic       c0_tc, c0_co, c0_bh, c1_tc, c1_co, c1_bh;

   counter_updown_mod #(.N(4), .PRESCALE(1)) dut_c0 (
      .clock(clock), .reset_n(reset_n), .clear(c_clr), .load(1'b0),
      .load_value(4'd0), .enable(c_en), .dec(1'b0), .mode(MODE_WRAP),
      .max_value(4'd9), .count(c0_count), .tc(c0_tc), .carry_out(c0_co),
      .boundary_hit(c0_bh)
   );

   counter_updown_mod #(.N(4), .PRESCALE(1)) dut_c1 (
      .clock(clock), .reset_n(reset_n), .clear(c_clr), .load(1'b0),
      .load_value(4'd0), .enable(c0_co), .dec(1'b0), .mode(MODE_WRAP),
      .max_value(4'd9), .count(c1_count), .tc(c1_tc), .carry_out(c1_co),
      .boundary_hit(c1_bh)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int sample = 0;

   task automatic cmp(input string name, input int idx, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s sample=%0d actual=%0d required=%0d", name, idx, act, req);
      end
   endtask

   logic [W-1:0] mon_e;
   logic [7:0]   obs_c;
   logic         obs_t, obs_o, obs_b;

   // Monitor: one observation per falling edge when an expectation is pending.
   initial begin
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e[16:15])
               2'd0:    begin obs_c = {4'd0, a_count}; obs_t = a_tc; obs_o = a_co; obs_b = a_bh; end
               2'd1:    begin obs_c = {4'd0, p_count}; obs_t = p_tc; obs_o = p_co; obs_b = p_bh; end
               default: begin obs_c = {c1_count, c0_count}; obs_t = c0_co; obs_o = c1_co; obs_b = c1_bh; end
            endcase
            if (mon_e[14]) cmp($sformatf("u%0d_count", mon_e[16:15]), sample, int'(obs_c), int'(mon_e[10:3]));
            if (mon_e[13]) cmp($sformatf("u%0d_tc", mon_e[16:15]), sample, int'(obs_t), int'(mon_e[2]));
            if (mon_e[12]) cmp($sformatf("u%0d_carry", mon_e[16:15]), sample, int'(obs_o), int'(mon_e[1]));
            if (mon_e[11]) cmp($sformatf("u%0d_bhit", mon_e[16:15]), sample, int'(obs_b), int'(mon_e[0]));
            sample++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Push the expectation for the current cycle, then move to just after the next rising edge.
   task automatic chk(input logic [1:0] s, input logic [3:0] m, input logic [7:0] c,
                      input logic t, input logic o, input logic b);
      exp_q.push_back({s, m, c, t, o, b});
      @(posedge clock);
      #1;
   endtask

   // Push an expectation that is sampled while reset is low, then release reset mid-cycle.
   task automatic reset_pulse(input logic [1:0] s);
      reset_n = 1'b0;
      exp_q.push_back({s, 4'b1111, 8'd0, 1'b0, 1'b0, 1'b0});
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b0;
      a_clr = 0; a_ld = 0; a_en = 0; a_dec = 1'b1; a_ldv = 4'd0; a_max = 4'd9; a_mode = MODE_WRAP;
      p_clr = 0; p_en = 0;
      c_clr = 0; c_en = 0;
      #1;

      // Reset state: tc must read 0 even though dec=1 with count=0.
      reset_pulse(2'd0);
      a_dec = 1'b0;

      // Up, wrap, max 9: 11 enabled cycles from 0.
      a_en = 1'b1;
      for (int j = 0; j <= 10; j++) begin
         chk(2'd0, 4'b1111, (j <= 9) ? 8'(j) : 8'd0, j == 9, j == 9, j == 10);
      end
      a_en = 1'b0;
      chk(2'd0, 4'b1111, 8'd1, 0, 0, 0);

      // Down, saturate: load 2 then 4 steps.
      a_dec = 1'b1; a_mode = MODE_SAT; a_ld = 1'b1; a_ldv = 4'd2;
      chk(2'd0, 4'b1111, 8'd1, 0, 0, 0);
      a_ld = 1'b0; a_en = 1'b1;
      chk(2'd0, 4'b1111, 8'd2, 0, 0, 0);
      chk(2'd0, 4'b1111, 8'd1, 0, 0, 0);
      chk(2'd0, 4'b1111, 8'd0, 1, 1, 0);
      chk(2'd0, 4'b1111, 8'd0, 1, 1, 1);
      a_en = 1'b0;
      chk(2'd0, 4'b1111, 8'd0, 1, 0, 1);
      chk(2'd0, 4'b1111, 8'd0, 1, 0, 0);

      // Load clamp: load 12 with max 9.
      a_dec = 1'b0; a_mode = MODE_WRAP; a_ld = 1'b1; a_ldv = 4'd12;
      chk(2'd0, 4'b1111, 8'd0, 0, 0, 0);
      a_ld = 1'b0;
      chk(2'd0, 4'b1111, 8'd9, 1, 0, 0);

      // Lowered modulus, up wrap: 8 with max 5 steps to 0.
      a_ld = 1'b1; a_ldv = 4'd8;
      chk(2'd0, 4'b1111, 8'd9, 1, 0, 0);
      a_ld = 1'b0; a_max = 4'd5; a_en = 1'b1;
      chk(2'd0, 4'b1111, 8'd8, 1, 1, 0);
      a_en = 1'b0;
      chk(2'd0, 4'b1111, 8'd0, 0, 0, 1);

      // Lowered modulus, down: 8 with max 5 steps to 5.
      a_max = 4'd9; a_ld = 1'b1; a_ldv = 4'd8;
      chk(2'd0, 4'b1111, 8'd0, 0, 0, 0);
      a_ld = 1'b0; a_max = 4'd5; a_dec = 1'b1; a_en = 1'b1;
      chk(2'd0, 4'b1111, 8'd8, 0, 0, 0);
      a_en = 1'b0; a_dec = 1'b0;
      chk(2'd0, 4'b1111, 8'd5, 1, 0, 0);

      // Degenerate modulus 0: every step is a boundary.
      a_max = 4'd0; a_en = 1'b1;
      chk(2'd0, 4'b1111, 8'd5, 1, 1, 0);
      chk(2'd0, 4'b1111, 8'd0, 1, 1, 1);
      a_en = 1'b0;
      chk(2'd0, 4'b1111, 8'd0, 1, 0, 1);
      chk(2'd0, 4'b1111, 8'd0, 1, 0, 0);

      // Priority: clear beats load beats a terminal step; boundary suppressed.
      a_max = 4'd9; a_ld = 1'b1; a_ldv = 4'd9;
      chk(2'd0, 4'b1111, 8'd0, 0, 0, 0);
      a_clr = 1'b1; a_ldv = 4'd3; a_en = 1'b1;
      chk(2'd0, 4'b1111, 8'd9, 1, 1, 0);
      a_clr = 1'b0; a_ld = 1'b0; a_en = 1'b0;
      chk(2'd0, 4'b1111, 8'd0, 0, 0, 0);

      // Asynchronous reset at count 7, then resume from 0.
      a_ld = 1'b1; a_ldv = 4'd7;
      chk(2'd0, 4'b1111, 8'd0, 0, 0, 0);
      a_ld = 1'b0;
      chk(2'd0, 4'b1111, 8'd7, 0, 0, 0);
      a_en = 1'b1;
      reset_pulse(2'd0);
      chk(2'd0, 4'b1111, 8'd1, 0, 0, 0);
      a_en = 1'b0;
      chk(2'd0, 4'b1111, 8'd2, 0, 0, 0);

      // Prescaler P=3: 9 enabled cycles with a pause after the fourth.
      p_clr = 1'b1;
      chk(2'd1, 4'b1010, 8'd0, 0, 0, 0);
      p_clr = 1'b0; p_en = 1'b1;
      chk(2'd1, 4'b1010, 8'd0, 0, 0, 0);   // enabled edge 1
      chk(2'd1, 4'b1010, 8'd0, 0, 0, 0);   // 2
      chk(2'd1, 4'b1010, 8'd0, 0, 0, 0);   // 3 (step)
      chk(2'd1, 4'b1010, 8'd1, 0, 0, 0);   // 4
      p_en = 1'b0;
      chk(2'd1, 4'b1010, 8'd1, 0, 0, 0);   // pause
      p_en = 1'b1;
      chk(2'd1, 4'b1010, 8'd1, 0, 0, 0);   // 5
      chk(2'd1, 4'b1010, 8'd1, 0, 0, 0);   // 6 (step)
      chk(2'd1, 4'b1010, 8'd2, 0, 0, 0);   // 7
      chk(2'd1, 4'b1010, 8'd2, 0, 0, 0);   // 8
      chk(2'd1, 4'b1010, 8'd2, 0, 0, 0);   // 9 (step)
      p_en = 1'b0;
      chk(2'd1, 4'b1010, 8'd3, 0, 0, 0);
      chk(2'd1, 4'b1010, 8'd3, 0, 0, 0);

      // Cascade: BCD 00..99 then 00, 01.
      c_en = 1'b1;
      for (int i = 0; i <= 101; i++) begin
         chk(2'd2, 4'b1111, {4'((i % 100) / 10), 4'(i % 10)}, (i % 10) == 9, i == 99, i == 100);
      end
      c_en = 1'b0;

      // Let the monitor drain the queue.
      repeat (3) @(negedge clock);
      cmp("queue_drain", sample, exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
